// File: rtl/pci_device_pkg.sv
// rtl/pci_device_pkg.sv - shared PCI command codes, FSM states and defaults for pci_device
// Purpose: constants and helpers imported by pci_device and pci_device_mem.
// Ports: none (package).
package pci_device_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;
    localparam int          ADDR_LSB          = 2;

    localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
    localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
    localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_TA,
        ST_READ,
        ST_WRITE,
        ST_DISC
    } state_e;

    function automatic logic is_read_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_READ_MULT) ||
               (cmd == CMD_MEM_READ_LINE);
    endfunction

    function automatic logic is_write_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_WRITE) || (cmd == CMD_MEM_WRITE_INV);
    endfunction

endpackage

// File: rtl/pci_device_mem.sv
// rtl/pci_device_mem.sv - word memory with byte-masked write port and registered read port
// Purpose: MEM_WORDS x 32 storage, cleared by reset.
// Ports: clk_i/rst_ni clock and async active-low reset; we_i/waddr_i/wdata_i/wbe_i
//        byte-masked write; raddr_i read address, rdata_o registered read data.
module pci_device_mem
    import pci_device_pkg::*;
#(
    parameter int MEM_WORDS = 4,
    parameter int WORD_BITS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [WORD_BITS-1:0] waddr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wbe_i,
    input  logic [WORD_BITS-1:0] raddr_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (we_i && wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pci_device.sv
// rtl/pci_device.sv - PCI-style memory target: decode, target FSM and AD/PAR tristate control
// Purpose: claims memory read/write commands in the BASE_ADDR window and serves
//          single or burst transfers, disconnecting at the last memory word.
// Ports: CLK/RST clock and async active-low reset; FRAME/IRDY/CBE master controls;
//        AD multiplexed address/data; TRDY/DEVSEL/STOP target controls; PAR read parity.
module pci_device
    import pci_device_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MEM_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME,
    inout  wire  [31:0] AD,
    input  logic [3:0]  CBE,
    input  logic        IRDY,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP,
    output wire         PAR
);

    localparam int                   WORD_BITS = $clog2(MEM_WORDS);
    localparam int                   HIT_LSB   = ADDR_LSB + WORD_BITS;
    localparam logic [WORD_BITS-1:0] LAST_IDX  = WORD_BITS'(MEM_WORDS - 1);

    state_e               state_q;
    logic [WORD_BITS-1:0] idx_q;
    logic [WORD_BITS-1:0] idx_d;
    logic                 trdy_q, devsel_q, stop_q;
    logic                 ad_oe_q, par_q, par_oe_q;
    logic                 frame_q;
    logic [31:0]          rdata;

    // Only the first FRAME-low cycle after an idle bus is an address phase;
    // this keeps data phases of other transactions from being decoded.
    wire addr_phase = !FRAME && frame_q;
    wire addr_hit   = AD[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB];
    wire cmd_rd     = is_read_cmd(CBE);
    wire cmd_wr     = is_write_cmd(CBE);
    wire [WORD_BITS-1:0] addr_idx = AD[HIT_LSB-1:ADDR_LSB];
    wire unused_ad  = ^AD[ADDR_LSB-1:0];

    // TRDY is only low in READ/WRITE, so this is a completed data phase.
    wire xfer   = !IRDY && !trdy_q;
    assign idx_d = idx_q + 1'b1;

    wire mem_we = (state_q == ST_WRITE) && xfer;
    // Prefetch the next word on a completed read phase so AD follows one cycle later.
    wire [WORD_BITS-1:0] mem_raddr = ((state_q == ST_READ) && xfer) ? idx_d : idx_q;

    pci_device_mem #(
        .MEM_WORDS(MEM_WORDS),
        .WORD_BITS(WORD_BITS)
    ) u_mem (
        .clk_i  (CLK),
        .rst_ni (RST),
        .we_i   (mem_we),
        .waddr_i(idx_q),
        .wdata_i(AD),
        .wbe_i  (CBE),
        .raddr_i(mem_raddr),
        .rdata_o(rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            frame_q  <= 1'b1;
        end else begin
            frame_q <= FRAME;
            case (state_q)
                ST_IDLE: begin
                    if (addr_phase && addr_hit && (cmd_rd || cmd_wr)) begin
                        idx_q    <= addr_idx;
                        devsel_q <= 1'b0;
                        if (cmd_wr) begin
                            state_q <= ST_WRITE;
                            trdy_q  <= 1'b0;
                            stop_q  <= !(addr_idx == LAST_IDX);
                        end else begin
                            state_q <= ST_READ_TA;
                        end
                    end
                end
                ST_READ_TA: begin
                    state_q <= ST_READ;
                    trdy_q  <= 1'b0;
                    ad_oe_q <= 1'b1;
                    stop_q  <= !(idx_q == LAST_IDX);
                end
                ST_READ, ST_WRITE: begin
                    if (xfer) begin
                        if (FRAME) begin
                            state_q  <= ST_IDLE;
                            trdy_q   <= 1'b1;
                            devsel_q <= 1'b1;
                            stop_q   <= 1'b1;
                            ad_oe_q  <= 1'b0;
                        end else if (idx_q == LAST_IDX) begin
                            // STOP is already low for this word: disconnect with data.
                            state_q <= ST_DISC;
                            trdy_q  <= 1'b1;
                            ad_oe_q <= 1'b0;
                        end else begin
                            idx_q  <= idx_d;
                            stop_q <= !(idx_d == LAST_IDX);
                        end
                    end
                end
                ST_DISC: begin
                    if (FRAME && !IRDY) begin
                        state_q  <= ST_IDLE;
                        devsel_q <= 1'b1;
                        stop_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    trdy_q   <= 1'b1;
                    devsel_q <= 1'b1;
                    stop_q   <= 1'b1;
                    ad_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    // PAR trails the AD value it covers by one clock and releases one clock after AD.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_q    <= 1'b0;
            par_oe_q <= 1'b0;
        end else begin
            par_q    <= ^{rdata, CBE};
            par_oe_q <= ad_oe_q;
        end
    end

    assign AD     = ad_oe_q ? rdata : 32'hzzzz_zzzz;
    assign PAR    = par_oe_q ? par_q : 1'bz;
    assign TRDY   = trdy_q;
    assign DEVSEL = devsel_q;
    assign STOP   = stop_q;

endmodule

// File: tb/tb_pci_device.sv
// tb/tb_pci_device.sv - scoreboard testbench for pci_device with randomized transactions
module tb_pci_device;
    import pci_device_pkg::*;

    localparam int NW = 4;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
        logic        stop;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b1;
    logic        irdy  = 1'b1;
    logic [3:0]  cbe   = 4'h0;
    logic        m_oe  = 1'b0;
    logic [31:0] m_ad  = '0;
    wire  [31:0] ad;
    wire         par;
    logic        trdy, devsel, stop;

    assign ad = m_oe ? m_ad : 32'hzzzz_zzzz;
    for (genvar gi = 0; gi < 32; gi++) begin : g_pu
        pullup pu (ad[gi]);
    end
    pullup pu_par (par);

    always #5 clk = ~clk;

    pci_device #(
        .BASE_ADDR(32'hFFFF_0000),
        .MEM_WORDS(NW)
    ) dut (
        .CLK   (clk),
        .RST   (rst_n),
        .FRAME (frame),
        .AD    (ad),
        .CBE   (cbe),
        .IRDY  (irdy),
        .TRDY  (trdy),
        .DEVSEL(devsel),
        .STOP  (stop),
        .PAR   (par)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] model [NW];
    logic [31:0] wdata [8];
    logic [3:0]  wbe   [8];
    logic [31:0] base_v = 32'hFFFF_0000;
    logic        quiet    = 1'b0;
    logic        par_pend = 1'b0;
    logic        par_exp  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endfunction

    // Monitor: pops an expectation at every completed data phase.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (par_pend) begin
                chk("par", 32'(par), 32'(par_exp));
                par_pend = 1'b0;
            end
            if (quiet) begin
                chk("quiet_ctrl", 32'({devsel, trdy, stop}), 32'h7);
                if (!m_oe) chk("quiet_ad", ad, 32'hFFFF_FFFF);
            end
            if (!irdy && !trdy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_xfer", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_stop", 32'(stop), 32'(e.stop));
                    chk("xfer_devsel", 32'(devsel), 32'(0));
                    if (e.rd) begin
                        chk("rd_data", ad, e.data);
                        par_pend = 1'b1;
                        par_exp  = ^{e.data, cbe};
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                            input int stall_p, input int stall_len);
        logic rd, wr, hit, t_n, s_n, stalling, ending, done, seen_dev;
        int   start, nx, p, cyc, lat, disc_n, stall_left, exp_disc, exp_lat;
        exp_t e;
        rd    = cmd inside {CMD_MEM_READ, CMD_MEM_READ_MULT, CMD_MEM_READ_LINE};
        wr    = cmd inside {CMD_MEM_WRITE, CMD_MEM_WRITE_INV};
        hit   = (rd || wr) && (addr[31:4] == base_v[31:4]);
        start = int'(addr[3:2]);
        nx    = 0;
        if (hit) begin
            nx = (n < NW - start) ? n : NW - start;
            for (int k = 0; k < nx; k++) begin
                e.rd   = rd;
                e.data = model[start + k];
                e.stop = (start + k != NW - 1);
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbe[k][b]) model[start + k][8*b +: 8] = wdata[k][8*b +: 8];
                    end
                end
                sb_q.push_back(e);
            end
        end
        exp_disc = (hit && n > nx) ? ((n - nx == 1) ? 1 : 3) : 0;
        exp_lat  = hit ? (wr ? 1 : 2) : -1;
        quiet    = !hit;

        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; m_oe = 1'b1; m_ad = addr; cbe = cmd;
        @(posedge clk); #1;

        p = 0; cyc = 0; lat = -1; disc_n = 0; stall_left = stall_len;
        done = 1'b0; ending = 1'b0; seen_dev = 1'b0;
        while (!done) begin
            stalling = hit && (p == stall_p) && (p < nx) && (stall_left > 0);
            irdy  = stalling;
            frame = (ending || p == n - 1);
            m_oe  = !rd;
            m_ad  = wdata[p];
            cbe   = wbe[p];
            @(negedge clk);
            t_n = trdy; s_n = stop;
            if (!devsel) seen_dev = 1'b1;
            if (stalling) chk("trdy_in_stall", 32'(t_n), 32'(0));
            if (!stalling && t_n && !s_n) disc_n++;
            @(posedge clk); #1;
            cyc++;
            if (!stalling && !t_n) begin
                if (lat < 0) lat = cyc;
                p++;
                if (frame) done = 1'b1;
            end else if (stalling) begin
                stall_left--;
            end else if (frame && (ending || (t_n && !s_n))) begin
                done = 1'b1;
            end
            if (!done && !frame && t_n && !s_n && disc_n >= 2) ending = 1'b1;
            if (!done && !seen_dev && cyc >= 4) ending = 1'b1;
            if (!done && cyc >= 40) begin
                chk("xfer_timeout", 32'(cyc), 32'(0));
                done = 1'b1;
            end
        end

        frame = 1'b1; irdy = 1'b1; m_oe = 1'b0; cbe = 4'h0;
        @(negedge clk);
        chk("idle_ctrl", 32'({devsel, trdy, stop}), 32'h7);
        chk("idle_ad", ad, 32'hFFFF_FFFF);
        chk("first_lat", 32'(lat), 32'(exp_lat));
        chk("disc_cycles", 32'(disc_n), 32'(exp_disc));
        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        sb_q.delete();
        quiet = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] rd_cmds [3];
        logic [3:0] wr_cmds [2];
        logic [3:0] bad_cmds [5];
        logic [3:0] cmd;
        logic [31:0] addr;
        int r;
        rd_cmds  = '{CMD_MEM_READ, CMD_MEM_READ_MULT, CMD_MEM_READ_LINE};
        wr_cmds  = '{CMD_MEM_WRITE, CMD_MEM_WRITE_INV};
        bad_cmds = '{4'b0010, 4'b0011, 4'b0000, 4'b1010, 4'b1011};
        for (int i = 0; i < NW; i++) model[i] = '0;
        for (int i = 0; i < 8; i++) begin wdata[i] = '0; wbe[i] = 4'hF; end

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 32'({devsel, trdy, stop, par}), 32'hF);
        chk("reset_ad", ad, 32'hFFFF_FFFF);
        @(posedge clk); #1 rst_n = 1'b1;

        run_xfer(CMD_MEM_READ, 32'hFFFF_0000, 1, 7, 0);
        wdata[0] = 32'h0000_F0F0;
        run_xfer(CMD_MEM_WRITE, 32'hFFFF_0000, 1, 7, 0);
        run_xfer(CMD_MEM_READ, 32'hFFFF_0000, 1, 7, 0);
        for (int k = 0; k < 6; k++) wdata[k] = 32'h0000_F0F0 + 32'(k);
        run_xfer(CMD_MEM_WRITE, 32'hFFFF_0000, 6, 7, 0);
        run_xfer(CMD_MEM_READ_MULT, 32'hFFFF_0000, 4, 7, 0);
        for (int k = 0; k < 3; k++) wdata[k] = 32'hA5A5_0000 + 32'(k);
        run_xfer(CMD_MEM_WRITE, 32'hFFFF_0000, 3, 1, 2);
        run_xfer(CMD_MEM_READ_LINE, 32'hFFFF_0000, 4, 2, 1);
        run_xfer(CMD_MEM_WRITE, 32'h1234_0000, 2, 7, 0);
        run_xfer(CMD_MEM_READ, 32'h1234_0000, 2, 7, 0);
        run_xfer(4'b0010, 32'hFFFF_0000, 1, 7, 0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      cmd = rd_cmds[$urandom_range(0, 2)];
            else if (r < 8) cmd = wr_cmds[$urandom_range(0, 1)];
            else            cmd = bad_cmds[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = {16'hFFFF, 12'h000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            for (int k = 0; k < 8; k++) begin
                wdata[k] = $urandom;
                wbe[k]   = 4'($urandom_range(0, 15));
            end
            run_xfer(cmd, addr, $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 2));
        end

        // Reset while the target is driving read data.
        for (int k = 0; k < 8; k++) wbe[k] = 4'hF;
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; m_oe = 1'b1; m_ad = 32'hFFFF_0004; cbe = CMD_MEM_READ;
        @(posedge clk); #1;
        m_oe = 1'b0; cbe = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_ad", ad, model[1]);
        chk("pre_reset_trdy", 32'(trdy), 32'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_ctrl", 32'({devsel, trdy, stop, par}), 32'hF);
        chk("mid_reset_ad", ad, 32'hFFFF_FFFF);
        frame = 1'b1;
        for (int i = 0; i < NW; i++) model[i] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_xfer(CMD_MEM_READ_MULT, 32'hFFFF_0000, 4, 7, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
